// File: rtl/elevator_pkg.sv
// Shared state encodings and pending-mask helpers for the N-floor elevator controller.
package elevator_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] DOOR = 2'd2;

  // Helpers take a zero-extended pending vector so one function serves any floor count up to this.
  localparam int MAX_FLOORS = 32;

  function automatic logic any_above(input logic [MAX_FLOORS-1:0] pend, input int fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i > fl) r = r | pend[i];
    end
    return r;
  endfunction

  function automatic logic any_below(input logic [MAX_FLOORS-1:0] pend, input int fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i < fl) r = r | pend[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter with enable; zero flags when the count has expired.
module elev_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && !zero) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor SCAN elevator controller: latches requests, travels one floor per MOVE_CYCLES,
// and holds the door open for DOOR_CYCLES at each served floor.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 4,
  parameter int MOVE_CYCLES = 3,
  parameter int DOOR_CYCLES = 2,
  localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  logic [1:0]            state_reg, state_next;
  logic [FLOOR_W-1:0]    floor_reg, floor_next;
  logic                  dir_up_reg, dir_up_next;
  logic [NUM_FLOORS-1:0] pending_reg, pending_next;
  logic [NUM_FLOORS-1:0] clr;
  logic [MAX_FLOORS-1:0] pend_ext;
  logic [FLOOR_W-1:0]    step_floor;
  logic                  above, below, here, ahead_at_step;
  logic                  move_load, door_load, move_zero, door_zero;

  assign pend_ext      = MAX_FLOORS'(pending_reg);
  assign above         = any_above(pend_ext, int'(floor_reg));
  assign below         = any_below(pend_ext, int'(floor_reg));
  assign here          = pending_reg[floor_reg];
  assign step_floor    = dir_up_reg ? (floor_reg + FLOOR_W'(1)) : (floor_reg - FLOOR_W'(1));
  assign ahead_at_step = dir_up_reg ? any_above(pend_ext, int'(step_floor))
                                    : any_below(pend_ext, int'(step_floor));

  always_comb begin
    state_next  = state_reg;
    floor_next  = floor_reg;
    dir_up_next = dir_up_reg;
    move_load   = 1'b0;
    door_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (here) begin
          state_next = DOOR;
          door_load  = 1'b1;
        end else if ((dir_up_reg & above) | (~dir_up_reg & ~below & above)) begin
          dir_up_next = 1'b1;
          state_next  = MOVE;
          move_load   = 1'b1;
        end else if (below) begin
          dir_up_next = 1'b0;
          state_next  = MOVE;
          move_load   = 1'b1;
        end
      end
      MOVE: begin
        // Arrival: the stop/continue decision looks at the floor being reached, not the one left.
        if (move_zero) begin
          floor_next = step_floor;
          if (pending_reg[step_floor]) begin
            state_next = DOOR;
            door_load  = 1'b1;
          end else if (ahead_at_step) begin
            move_load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DOOR: begin
        if (door_zero) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Clearing on entry and throughout DOOR is what absorbs calls for the floor being served.
  always_comb begin
    clr = '0;
    if ((state_next == DOOR) || (state_reg == DOOR)) begin
      clr = NUM_FLOORS'(1) << floor_next;
    end
    pending_next = (pending_reg | req) & ~clr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      floor_reg   <= '0;
      dir_up_reg  <= 1'b1;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      floor_reg   <= floor_next;
      dir_up_reg  <= dir_up_next;
      pending_reg <= pending_next;
    end
  end

  elev_timer #(.W(CNT_W)) u_move_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (move_load),
    .load_val (CNT_W'(MOVE_CYCLES - 1)),
    .en       (state_reg == MOVE),
    .zero     (move_zero)
  );

  elev_timer #(.W(CNT_W)) u_door_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (door_load),
    .load_val (CNT_W'(DOOR_CYCLES - 1)),
    .en       (state_reg == DOOR),
    .zero     (door_zero)
  );

  assign floor     = floor_reg;
  assign dir_up    = dir_up_reg;
  assign moving    = (state_reg == MOVE);
  assign door_open = (state_reg == DOOR);
  assign pending   = pending_reg;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Cycle-accurate directed bench for elevator_ctrl_n at the default 4 floors / 3 move / 2 door cycles.
module tb_elevator_ctrl_n;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [1:0] floor;
  logic       dir_up;
  logic       moving;
  logic       door_open;
  logic [3:0] pending;

  int checks;
  int passed;

  typedef struct packed {
    logic [3:0] req;
    logic [1:0] fl;
    logic       d;
    logic       m;
    logic       dr;
    logic [3:0] p;
  } vec_t;

  vec_t tbl[$];

  elevator_ctrl_n dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .floor     (floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish earlier");
    $fatal(1, "watchdog");
  end

  // Check this cycle's outputs at the falling edge, then drive req for the rest of the cycle.
  task automatic step(input logic [3:0] r, input string nm, input logic [1:0] fl,
                      input logic d, input logic m, input logic dr, input logic [3:0] p);
    logic [8:0] act;
    logic [8:0] exp;
    act = {floor, dir_up, moving, door_open, pending};
    exp = {fl, d, m, dr, p};
    checks++;
    if (act === exp) begin
      passed++;
      $display("ok   %s floor=%0d dir_up=%b moving=%b door_open=%b pending=%b req=%b",
               nm, floor, dir_up, moving, door_open, pending, r);
    end else begin
      $display("FAIL %s: got floor=%0d dir_up=%b moving=%b door_open=%b pending=%b, expected floor=%0d dir_up=%b moving=%b door_open=%b pending=%b",
               nm, floor, dir_up, moving, door_open, pending, fl, d, m, dr, p);
    end
    req = r;
    @(negedge clk);
  endtask

  task automatic hold(input int n, input string nm, input logic [1:0] fl,
                      input logic d, input logic m, input logic dr, input logic [3:0] p);
    for (int i = 0; i < n; i++) step(4'b0000, nm, fl, d, m, dr, p);
  endtask

  task automatic add(input int n, input logic [3:0] r, input logic [1:0] fl,
                     input logic d, input logic m, input logic dr, input logic [3:0] p);
    vec_t v;
    v = '{req: r, fl: fl, d: d, m: m, dr: dr, p: p};
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req   = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    req    = 4'b0000;

    // idle after reset, 10 cycles
    add(10, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    // call at the current floor (0): door next cycle after latching, no motion
    add(1,  4'b0001, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    add(1,  4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0001);
    add(2,  4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000);
    add(1,  4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    // call to floor 3: three floors at 3 cycles each, 2-cycle door
    add(1,  4'b1000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    add(1,  4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b1000);
    add(3,  4'b0000, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1000);
    add(3,  4'b0000, 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000);
    add(3,  4'b0000, 2'd2, 1'b1, 1'b1, 1'b0, 4'b1000);
    add(2,  4'b0000, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000);
    add(2,  4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000);

    reset_dut();
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].req, $sformatf("tbl[%0d]", k), tbl[k].fl, tbl[k].d, tbl[k].m, tbl[k].dr, tbl[k].p);
    end

    // current-floor call during DOOR is absorbed and does not stretch the door
    step(4'b1000, "absorb_req",    2'd3, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(4'b0000, "absorb_latch",  2'd3, 1'b1, 1'b0, 1'b0, 4'b1000);
    step(4'b1000, "absorb_door0",  2'd3, 1'b1, 1'b0, 1'b1, 4'b0000);
    step(4'b1000, "absorb_door1",  2'd3, 1'b1, 1'b0, 1'b1, 4'b0000);
    hold(2,       "absorb_closed", 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000);

    // reset while travelling 1->2 with floor 3 pending; a request in the reset cycle is dropped
    reset_dut();
    step(4'b1000, "rst_req",     2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(4'b0000, "rst_latch",   2'd0, 1'b1, 1'b0, 1'b0, 4'b1000);
    hold(3,       "rst_move0",   2'd0, 1'b1, 1'b1, 1'b0, 4'b1000);
    step(4'b0000, "rst_move1a",  2'd1, 1'b1, 1'b1, 1'b0, 4'b1000);
    reset = 1'b1;
    step(4'b0100, "rst_move1b",  2'd1, 1'b1, 1'b1, 1'b0, 4'b1000);
    reset = 1'b0;
    hold(3,       "rst_after",   2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);

    // SCAN: heading up to 2, then 0 and 3 requested at floor 1; serve 2, 3, then reverse to 0
    reset_dut();
    step(4'b0100, "scan_req2",   2'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(4'b0000, "scan_latch",  2'd0, 1'b1, 1'b0, 1'b0, 4'b0100);
    hold(3,       "scan_m0",     2'd0, 1'b1, 1'b1, 1'b0, 4'b0100);
    step(4'b1001, "scan_req03",  2'd1, 1'b1, 1'b1, 1'b0, 4'b0100);
    hold(2,       "scan_m1",     2'd1, 1'b1, 1'b1, 1'b0, 4'b1101);
    hold(2,       "scan_door2",  2'd2, 1'b1, 1'b0, 1'b1, 4'b1001);
    hold(1,       "scan_idle2",  2'd2, 1'b1, 1'b0, 1'b0, 4'b1001);
    hold(3,       "scan_m2",     2'd2, 1'b1, 1'b1, 1'b0, 4'b1001);
    hold(2,       "scan_door3",  2'd3, 1'b1, 1'b0, 1'b1, 4'b0001);
    hold(1,       "scan_idle3",  2'd3, 1'b1, 1'b0, 1'b0, 4'b0001);
    hold(3,       "scan_m3dn",   2'd3, 1'b0, 1'b1, 1'b0, 4'b0001);
    hold(3,       "scan_m2dn",   2'd2, 1'b0, 1'b1, 1'b0, 4'b0001);
    hold(3,       "scan_m1dn",   2'd1, 1'b0, 1'b1, 1'b0, 4'b0001);
    hold(2,       "scan_door0",  2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
    hold(2,       "scan_done",   2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
Parametrised N-floor elevator controller and successor to the two-floor toggle controller. Latches floor requests into a pending set and serves them in SCAN order, continuing in one direction while requests lie ahead. Models per-floor travel time and a door-open dwell. Sits between the request/button logic and the car/door actuator and display logic.

Parameters:
NUM_FLOORS, 4, number of floors (>=2); floor 0 is ground.
FLOOR_W, $clog2(NUM_FLOORS), width of the floor index (derived localparam, not overridable).
MOVE_CYCLES, 3, clock cycles to travel one floor (>=1).
DOOR_CYCLES, 2, clock cycles the door stays open per stop (>=1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req  input  NUM_FLOORS  request bits; bit i = call to floor i; a one-cycle pulse is sufficient.
floor  output  FLOOR_W  current floor index.
dir_up  output  1  current or last travel direction: 1 = up, 0 = down.
moving  output  1  high while in state MOVE.
door_open  output  1  high while in state DOOR.
pending  output  NUM_FLOORS  latched, not-yet-served requests.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. All state is registered.
- Reset values: floor=0, dir_up=1, moving=0, door_open=0, pending=0, state=IDLE, counters=0. Reset mid-move or mid-door aborts to these values immediately; requests asserted in the reset cycle are dropped.
- pending update every cycle: pending <= (pending | req) & ~clr.
  - clr is one-hot(floor) on the cycle the FSM enters DOOR, and every cycle while in DOOR; otherwise clr = 0.
  - A request for the current floor while the door is open is absorbed: it never appears in pending, and the door timer is not extended.
- Decisions use the registered pending only. A request pulsed in cycle t appears in pending at t+1 and can first cause a state change at the edge ending cycle t+1.
- Helper terms: above = |pending[NUM_FLOORS-1:floor+1]; below = |pending[floor-1:0]; here = pending[floor]. A term is 0 when its range is empty.
- State IDLE (moving=0, door_open=0):
  - If here: go to DOOR and load door_cnt = DOOR_CYCLES-1.
  - Else if (dir_up & above) | (~dir_up & ~below & above): set dir_up=1, go to MOVE, load move_cnt = MOVE_CYCLES-1.
  - Else if below: set dir_up=0, go to MOVE, load move_cnt.
  - Else stay in IDLE.
- State MOVE (moving=1):
  - move_cnt decrements each cycle.
  - When move_cnt==0: floor <= floor+1 if dir_up, else floor-1.
  - On that same edge the next state is evaluated against the new floor:
    - pending[new floor] -> DOOR.
    - Else requests remain ahead in dir_up -> stay in MOVE and reload move_cnt.
    - Else -> IDLE.
  - floor never leaves the range 0..NUM_FLOORS-1, because motion occurs only toward a pending bit.
- State DOOR (door_open=1):
  - door_cnt decrements each cycle.
  - When door_cnt==0: go to IDLE.
  - door_open is high for exactly DOOR_CYCLES consecutive cycles per stop.
- Direction reverses only from IDLE, and only when nothing is pending ahead.
- A request for a floor the car is passing mid-travel is served only if it is latched before the arrival edge at that floor.

Decomposition:
- Package elevator_pkg holds the state enum (IDLE, MOVE, DOOR) and a function for the above/below masks (any_above, any_below) parametrised by floor index.
- One sub-module is natural: elev_timer, a down-counter with load, enable and zero flag. Instantiate it twice, once for move_cnt and once for door_cnt.
- The FSM and pending register stay in the top level.

Test Plan:
All scenarios use the defaults: NUM_FLOORS=4, MOVE_CYCLES=3, DOOR_CYCLES=2.
- Reset then idle, req=0 for 10 cycles -> floor=0, moving=0, door_open=0, pending=0 throughout.
- From floor 0, pulse req=4'b1000 at cycle 0 -> pending=1000 at cycle 1; moving=1 from cycle 2; floor steps 1,2,3 every 3 cycles; door_open=1 for exactly 2 cycles at floor 3; pending=0; then IDLE with dir_up=1.
- At floor 0, pulse req=4'b0001 -> DOOR entered the next cycle with no motion; door_open high for 2 cycles; pending bit 0 cleared.
- SCAN ordering: car at floor 1 moving up, pending=0100, then pulse req=4'b0001 plus req=4'b1000 -> stops at 2, then 3, then reverses and stops at 0; dir_up goes 1->0 only in IDLE after the floor-3 door closes.
- Request at the current floor during DOOR (req=one-hot(floor)) -> pending stays 0 and door_open still lasts exactly 2 cycles.
- Assert reset for 1 cycle while moving between floors 1 and 2 with pending=1000 -> next cycle floor=0, pending=0, moving=0, dir_up=1.
